// File: rtl/config_frame_sequencer.sv
// Configuration frame sequencer: accepts frame write requests and drives FrameData
// plus a one-hot FrameStrobe through SETUP -> STROBE -> HOLD timing for a fabric column.
module config_frame_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 1
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [4:0]                 cfg_addr,
  input  logic [FrameBitsPerRow-1:0] cfg_data,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_addr,
  output logic [15:0]                frame_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  // Phase counter counts down to zero; load values are "length - 1".
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
  localparam logic [5:0] NUM_FRAMES = 6'(MaxFramesPerCol);

  state_e                     state_q, state_d;
  logic [3:0]                 phase_q, phase_d;
  logic [4:0]                 addr_q, addr_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       err_q, err_d;
  logic                       accept, addr_ok;

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign accept      = cfg_valid && cfg_ready;
  assign addr_ok     = ({1'b0, cfg_addr} < NUM_FRAMES);
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign err_addr    = err_q;
  assign frame_cnt   = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    strobe_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && addr_ok) begin
          state_d = SETUP;
          phase_d = SETUP_LD;
          addr_d  = cfg_addr;
          data_d  = cfg_data;
        end
      end
      SETUP: begin
        if (phase_q == 4'd0) begin
          state_d     = STROBE;
          phase_d     = STROBE_LD;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      STROBE: begin
        if (phase_q == 4'd0) begin
          state_d = HOLD;
          phase_d = 4'd0;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
    endcase

    // A new bad address in the same cycle as a clear keeps the flag set.
    if (accept && !addr_ok) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;

    // Strobe register mirrors the next state so it is high exactly during STROBE.
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      strobe_d[i] = (state_d == STROBE) && (addr_d == 5'(i));
    end
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      addr_q      <= 5'd0;
      data_q      <= '0;
      strobe_q    <= '0;
      frame_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Bench for config_frame_sequencer: default-timing and 15/15-timing instances share
// stimulus; a cycle-indexed timeline model predicts every output each cycle.
module tb_config_frame_sequencer;

  logic        UserCLK = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        err_clr = 1'b0;

  logic        o_ready [2];
  logic [31:0] o_data  [2];
  logic [19:0] o_strb  [2];
  logic        o_busy  [2];
  logic        o_err   [2];
  logic [15:0] o_cnt   [2];

  always #5 UserCLK = ~UserCLK;

  config_frame_sequencer dut0 (
    .UserCLK(UserCLK), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o_ready[0]),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err_clr(err_clr),
    .FrameData(o_data[0]), .FrameStrobe(o_strb[0]), .busy(o_busy[0]),
    .err_addr(o_err[0]), .frame_cnt(o_cnt[0])
  );

  config_frame_sequencer #(.SETUP_CYCLES(15), .STROBE_CYCLES(15)) dut1 (
    .UserCLK(UserCLK), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o_ready[1]),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err_clr(err_clr),
    .FrameData(o_data[1]), .FrameStrobe(o_strb[1]), .busy(o_busy[1]),
    .err_addr(o_err[1]), .frame_cnt(o_cnt[1])
  );

  // Timeline model: each accepted frame is a set of absolute cycle numbers.
  int          S [2] = '{2, 15};
  int          T [2] = '{1, 15};
  longint      cyc = 0;
  longint      ready_at [2];
  longint      s0 [2];
  longint      s1 [2];
  int          saddr [2];
  logic [31:0] edata [2];
  logic [15:0] ecnt [2];
  bit          eerr [2];
  bit          cnt_forced = 1'b0;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input int inst, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit acc [2];
    for (int i = 0; i < 2; i++) acc[i] = cfg_valid && (cyc >= ready_at[i]) && !rst;
    @(posedge UserCLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ready_at[i] = cyc + 1;
        s0[i] = -1; s1[i] = -2;
        edata[i] = '0; ecnt[i] = '0; eerr[i] = 1'b0;
      end else begin
        if (acc[i] && cfg_addr < 20) begin
          edata[i]    = cfg_data;
          saddr[i]    = int'(cfg_addr);
          s0[i]       = cyc + S[i] + 1;
          s1[i]       = cyc + S[i] + T[i];
          ready_at[i] = cyc + S[i] + T[i] + 2;
        end
        if (acc[i] && cfg_addr >= 20) eerr[i] = 1'b1;
        else if (err_clr)             eerr[i] = 1'b0;
      end
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic [63:0] es;
      if (!rst && cyc == s0[i]) ecnt[i] = ecnt[i] + 16'd1;
      if (cnt_forced) ecnt[i] = 16'hFFFF;
      es = (cyc >= s0[i] && cyc <= s1[i]) ? (64'd1 << saddr[i]) : 64'd0;
      chk("cfg_ready",   i, 64'(o_ready[i]), 64'(cyc >= ready_at[i]));
      chk("busy",        i, 64'(o_busy[i]),  64'(cyc < ready_at[i]));
      chk("FrameStrobe", i, 64'(o_strb[i]),  es);
      chk("FrameData",   i, 64'(o_data[i]),  64'(edata[i]));
      chk("frame_cnt",   i, 64'(o_cnt[i]),   64'(ecnt[i]));
      chk("err_addr",    i, 64'(o_err[i]),   64'(eerr[i]));
    end
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < ready_at[0] || cyc < ready_at[1]) && n < 100) begin
      step();
      n++;
    end
    chk("wait_idle_bound", 0, 64'(n < 100), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ready_at[i] = 0; s0[i] = -1; s1[i] = -2; saddr[i] = 0;
      edata[i] = '0; ecnt[i] = '0; eerr[i] = 1'b0;
    end
    #1;
    // Reset state
    step(); step();
    rst = 1'b0;
    step();

    // Single write, addr 3
    write1(5'd3, 32'hA5A5_0001);
    wait_idle();
    chk("cnt_after_single", 0, 64'(o_cnt[0]), 64'd1);

    // Back-to-back with cfg_valid held: addr 0 then addr 19
    cfg_valid = 1'b1; cfg_addr = 5'd0; cfg_data = 32'h0000_1111;
    step();
    cfg_addr = 5'd19; cfg_data = 32'h1919_1919;
    for (int k = 0; k < 6; k++) step();
    cfg_valid = 1'b0;
    wait_idle();

    // Out-of-range address, clear, clear colliding with a new error
    write1(5'd25, 32'hDEAD_BEEF);
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    step();
    write1(5'd20, 32'h0);
    err_clr = 1'b1; cfg_valid = 1'b1; cfg_addr = 5'd31; step();
    err_clr = 1'b0; cfg_valid = 1'b0;
    step();
    chk("err_set_wins", 0, 64'(o_err[0]), 64'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Reset during STROBE of addr 7, then a normal write
    write1(5'd7, 32'h0777_0777);
    for (int k = 0; k < 10 && cyc != s0[0]; k++) step();
    chk("in_strobe", 0, 64'(o_strb[0]), 64'h80);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_strobe", 0, 64'(o_strb[0]), 64'd0);
    chk("rst_cnt",    0, 64'(o_cnt[0]),  64'd0);
    write1(5'd5, 32'h5555_AAAA);
    wait_idle();

    // Counter wrap from 0xFFFF
    force dut0.frame_cnt_q = 16'hFFFF;
    force dut1.frame_cnt_q = 16'hFFFF;
    cnt_forced = 1'b1;
    step();
    release dut0.frame_cnt_q;
    release dut1.frame_cnt_q;
    cnt_forced = 1'b0;
    write1(5'd2, 32'h2222_2222);
    wait_idle();
    chk("cnt_wrap", 0, 64'(o_cnt[0]), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_addr  = 5'($urandom_range(0, 31));
      cfg_data  = $urandom;
      err_clr   = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    cfg_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
